c_fetch_align_buffer: RTL

- Fetch-side stage directly upstream of the compressed-extension unit.
- Accepts word-aligned 32-bit fetch data and buffers it as 16-bit halfwords.
- Delivers one instruction per handshake, aligned to bit 0, with its PC and a compressed flag; 32-bit instructions may straddle word boundaries.
- Handles redirects to halfword-aligned targets (pc[1]=1).

---
 rtl/c_ext_pkg.sv | 14 +
 rtl/c_hw_fifo.sv | 64 ++++++
 rtl/c_fetch_align_buffer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/c_ext_pkg.sv
// Shared types and helpers for the compressed-extension fetch path.
package c_ext_pkg;

    typedef logic [15:0] halfword_t;

    localparam logic [1:0]  OPC_FULL         = 2'b11;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // A halfword starts a 16-bit instruction unless its low opcode bits are 2'b11.
    function automatic logic is_compressed(input halfword_t hw);
        return (hw[1:0] != OPC_FULL);
    endfunction

endpackage

// File: rtl/c_hw_fifo.sv
// Circular halfword buffer: up to two pushes and two pops per cycle, head pair exposed.
module c_hw_fifo
    import c_ext_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [1:0]       push_cnt,
    input  halfword_t        push_d0,
    input  halfword_t        push_d1,
    input  logic [1:0]       pop_cnt,
    output halfword_t        hw0,
    output halfword_t        hw1,
    output logic [CNT_W-1:0] count
);

    halfword_t        mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_ptr_p1_s;
    logic [PTR_W-1:0] wr_ptr_p1_s;

    assign rd_ptr_p1_s = rd_ptr_r + PTR_W'(1);
    assign wr_ptr_p1_s = wr_ptr_r + PTR_W'(1);

    assign hw0   = mem_r[rd_ptr_r];
    assign hw1   = mem_r[rd_ptr_p1_s];
    assign count = count_r;

    // Pointer and occupancy update; flush empties the buffer outright.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_cnt);
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt);
            count_r  <= count_r + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
        end
    end

    // Halfword storage; d0 lands at the write pointer, d1 just after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= 16'h0000;
            end
        end else if (!flush) begin
            if (push_cnt != 2'd0) begin
                mem_r[wr_ptr_r] <= push_d0;
            end
            if (push_cnt == 2'd2) begin
                mem_r[wr_ptr_p1_s] <= push_d1;
            end
        end
    end

endmodule

// File: rtl/c_fetch_align_buffer.sv
// Realigns word fetches into bit-0-aligned 16/32-bit instructions with PC.
// Optional counters (comp_cnt_o, starve_cnt_o) enabled by C_ALIGN_PERF_CNT_EN.
module c_fetch_align_buffer
    import c_ext_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned HW_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o
`ifdef C_ALIGN_PERF_CNT_EN
    ,
    output logic [31:0] comp_cnt_o,
    output logic [31:0] starve_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(HW_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_r;
    logic [31:0]      out_pc_r;
    logic             skip_lo_r;

    logic [CNT_W-1:0] count_s;
    halfword_t        hw0_s;
    halfword_t        hw1_s;
    logic             hw0_comp_s;
    logic             accept_s;
    logic             pop_s;
    logic             pop_two_s;
    logic [1:0]       push_cnt_s;
    logic [1:0]       pop_cnt_s;
    halfword_t        push_d0_s;
    halfword_t        push_d1_s;
    logic             unused_pc_bit_s;

    assign unused_pc_bit_s = redirect_pc_i[0];

    assign fetch_addr_o  = fetch_pc_r;
    assign instr_pc_o    = out_pc_r;
    assign fetch_ready_o = !redirect_i && (count_s <= CNT_W'(HW_DEPTH - 2));
    assign accept_s      = fetch_valid_i && fetch_ready_o;
    assign pop_s         = instr_valid_o && instr_ready_i;
    assign pop_cnt_s     = pop_s ? (pop_two_s ? 2'd2 : 2'd1) : 2'd0;

    // Select which halves of the accepted word enter the buffer.
    always_comb begin
        push_cnt_s = 2'd0;
        push_d0_s  = fetch_rdata_i[15:0];
        push_d1_s  = fetch_rdata_i[31:16];
        if (accept_s) begin
            if (skip_lo_r) begin
                push_cnt_s = 2'd1;
                push_d0_s  = fetch_rdata_i[31:16];
            end else begin
                push_cnt_s = 2'd2;
            end
        end else begin
            push_cnt_s = 2'd0;
        end
    end

    c_hw_fifo #(
        .DEPTH (HW_DEPTH)
    ) u_hw_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_i),
        .push_cnt (push_cnt_s),
        .push_d0  (push_d0_s),
        .push_d1  (push_d1_s),
        .pop_cnt  (pop_cnt_s),
        .hw0      (hw0_s),
        .hw1      (hw1_s),
        .count    (count_s)
    );

    // Present the head instruction; a 32-bit one waits until both halves are buffered.
    always_comb begin
        hw0_comp_s         = is_compressed(hw0_s);
        instr_valid_o      = 1'b0;
        instr_o            = 32'h0000_0000;
        instr_compressed_o = 1'b0;
        pop_two_s          = 1'b0;
        if (redirect_i) begin
            instr_valid_o = 1'b0;
        end else if (hw0_comp_s) begin
            if (count_s >= CNT_W'(1)) begin
                instr_valid_o      = 1'b1;
                instr_o            = {16'h0000, hw0_s};
                instr_compressed_o = 1'b1;
            end else begin
                instr_valid_o = 1'b0;
            end
        end else begin
            if (count_s >= CNT_W'(2)) begin
                instr_valid_o = 1'b1;
                instr_o       = {hw1_s, hw0_s};
                pop_two_s     = 1'b1;
            end else begin
                instr_valid_o = 1'b0;
            end
        end
    end

    // Fetch PC, output PC and the skip-low-half flag for halfword-aligned targets.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= {RESET_PC[31:2], 2'b00};
            out_pc_r   <= {RESET_PC[31:1], 1'b0};
            skip_lo_r  <= RESET_PC[1];
        end else if (redirect_i) begin
            fetch_pc_r <= {redirect_pc_i[31:2], 2'b00};
            out_pc_r   <= {redirect_pc_i[31:1], 1'b0};
            skip_lo_r  <= redirect_pc_i[1];
        end else begin
            if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
                skip_lo_r  <= 1'b0;
            end
            if (pop_s) begin
                out_pc_r <= out_pc_r + (pop_two_s ? 32'd4 : 32'd2);
            end
        end
    end

`ifdef C_ALIGN_PERF_CNT_EN
    logic [31:0] comp_cnt_r;
    logic [31:0] starve_cnt_r;

    assign comp_cnt_o   = comp_cnt_r;
    assign starve_cnt_o = starve_cnt_r;

    // Event counters survive redirects; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            comp_cnt_r   <= 32'd0;
            starve_cnt_r <= 32'd0;
        end else begin
            if (pop_s && instr_compressed_o) begin
                comp_cnt_r <= comp_cnt_r + 32'd1;
            end
            if (instr_ready_i && !instr_valid_o && !redirect_i) begin
                starve_cnt_r <= starve_cnt_r + 32'd1;
            end
        end
    end
`endif

endmodule
